// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order IF/ID/EXE/MEM/WB pipeline.
// A shift-register scoreboard of in-flight destinations drives stalls, bubbles, flushes and bypass selects.
module hazard_ctrl #(
    parameter int PIPE_DEPTH     = 3,
    parameter int ALU_FWD_STAGE  = 1,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int MEM_WAIT_MAX   = 15,
    parameter int CNT_W          = 16,
    localparam int SEL_W         = $clog2(PIPE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             instr_valid_d_i,
    input  logic [4:0]       rs1_idx_d_i,
    input  logic [4:0]       rs2_idx_d_i,
    input  logic             rs1_used_d_i,
    input  logic             rs2_used_d_i,
    input  logic [4:0]       rd_idx_d_i,
    input  logic             reg_write_en_d_i,
    input  logic             load_d_i,
    input  logic             taken_d_i,
    input  logic             dmem_req_m_i,
    input  logic             dmem_ready_m_i,
    output logic             enable_f_o,
    output logic             enable_d_o,
    output logic             flush_d_o,
    output logic             bubble_e_o,
    output logic             freeze_m_o,
    output logic [SEL_W-1:0] rs1_fwd_sel_o,
    output logic [SEL_W-1:0] rs2_fwd_sel_o,
    output logic             rs1_depended_h_o,
    output logic             rs2_depended_h_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    typedef sb_entry_t [PIPE_DEPTH-1:0] sb_vec_t;

    typedef struct packed {
        logic             hit;
        logic             not_ready;
        logic [SEL_W-1:0] sel;
    } match_t;

    sb_vec_t     sb_q;
    sb_entry_t   sb_in;
    match_t      m1;
    match_t      m2;
    logic        mem_wait;
    logic        raw_stall;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    function automatic match_t find_match(input sb_vec_t sb, input logic [4:0] idx,
                                          input logic used);
        match_t m = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (used && idx != 5'd0 && sb[k].valid && sb[k].rd == idx) begin
                m.hit       = 1'b1;
                m.sel       = SEL_W'(k + 1);
                m.not_ready = sb[k].is_load ? (k < LOAD_FWD_STAGE) : (k < ALU_FWD_STAGE);
            end
        end
        return m;
    endfunction

    always_comb begin
        m1 = find_match(sb_q, rs1_idx_d_i, rs1_used_d_i);
        m2 = find_match(sb_q, rs2_idx_d_i, rs2_used_d_i);
    end

    assign mem_wait  = dmem_req_m_i & ~dmem_ready_m_i;
    assign raw_stall = instr_valid_d_i & ((m1.hit & m1.not_ready) | (m2.hit & m2.not_ready));

    assign rs1_fwd_sel_o    = m1.sel;
    assign rs2_fwd_sel_o    = m2.sel;
    assign rs1_depended_h_o = m1.hit;
    assign rs2_depended_h_o = m2.hit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        enable_f_o = 1'b1;
        enable_d_o = 1'b1;
        flush_d_o  = 1'b0;
        bubble_e_o = 1'b0;
        freeze_m_o = 1'b0;
        // Reset forces the pipeline-control outputs to their idle values immediately.
        if (resetn) begin
            if (mem_wait) begin
                freeze_m_o = 1'b1;
                enable_f_o = 1'b0;
                enable_d_o = 1'b0;
            end else if (raw_stall) begin
                enable_f_o = 1'b0;
                enable_d_o = 1'b0;
                bubble_e_o = 1'b1;
            end else if (taken_d_i) begin
                flush_d_o = 1'b1;
            end
        end
    end

    // A stalled ID instruction is replaced by an empty slot; x0 writes are never tracked.
    always_comb begin
        sb_in = '0;
        if (!raw_stall) begin
            sb_in.valid   = instr_valid_d_i & reg_write_en_d_i & (rd_idx_d_i != 5'd0);
            sb_in.rd      = rd_idx_d_i;
            sb_in.is_load = load_d_i;
        end
    end

    always_comb begin
        wait_cnt_nxt = '0;
        if (mem_wait) begin
            wait_cnt_nxt = (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX)) ? wait_cnt_q
                                                                  : wait_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_q          <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
        end else begin
            if (!mem_wait) begin
                for (int k = 1; k < PIPE_DEPTH; k++) begin
                    sb_q[k] <= sb_q[k-1];
                end
                sb_q[0] <= sb_in;
            end
            wait_cnt_q <= wait_cnt_nxt;
            if (wait_cnt_nxt == WAIT_W'(MEM_WAIT_MAX)) begin
                mem_timeout_o <= 1'b1;
            end
            if ((mem_wait || raw_stall) && stall_cnt_o != {CNT_W{1'b1}}) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios with literal expectations,
// then randomized traffic compared every cycle against an in-flight-list model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int PIPE_DEPTH = 3;
    localparam int ALU_FWD    = 1;
    localparam int LOAD_FWD   = 2;
    localparam int WAIT_MAX   = 15;
    localparam int CNT_W      = 6;
    localparam int SEL_W      = $clog2(PIPE_DEPTH + 1);
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic resetn;
    logic instr_valid, rs1_used, rs2_used, reg_we, is_load, taken, dmem_req, dmem_ready;
    logic [4:0] rs1_idx, rs2_idx, rd_idx;
    logic enable_f, enable_d, flush_d, bubble_e, freeze_m, rs1_dep, rs2_dep, mem_timeout;
    logic [SEL_W-1:0] rs1_sel, rs2_sel;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .PIPE_DEPTH(PIPE_DEPTH), .ALU_FWD_STAGE(ALU_FWD), .LOAD_FWD_STAGE(LOAD_FWD),
        .MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .instr_valid_d_i(instr_valid),
        .rs1_idx_d_i(rs1_idx), .rs2_idx_d_i(rs2_idx),
        .rs1_used_d_i(rs1_used), .rs2_used_d_i(rs2_used),
        .rd_idx_d_i(rd_idx), .reg_write_en_d_i(reg_we), .load_d_i(is_load),
        .taken_d_i(taken), .dmem_req_m_i(dmem_req), .dmem_ready_m_i(dmem_ready),
        .enable_f_o(enable_f), .enable_d_o(enable_d), .flush_d_o(flush_d),
        .bubble_e_o(bubble_e), .freeze_m_o(freeze_m),
        .rs1_fwd_sel_o(rs1_sel), .rs2_fwd_sel_o(rs2_sel),
        .rs1_depended_h_o(rs1_dep), .rs2_depended_h_o(rs2_dep),
        .mem_timeout_o(mem_timeout), .stall_cnt_o(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model keeps the list of producers ahead of ID, youngest first.
    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } ent_t;

    typedef struct packed {
        bit             en_f, en_d, flush, bubble, freeze, d1, d2;
        bit [SEL_W-1:0] s1, s2;
    } exp_t;

    ent_t m_sb [PIPE_DEPTH];
    int   m_cnt = 0;
    int   m_run = 0;
    bit   m_to  = 1'b0;

    function automatic int lookup_sel(input logic [4:0] idx, input logic used);
        int sel = 0;
        if (used && idx != 0)
            for (int k = 0; k < PIPE_DEPTH; k++)
                if (sel == 0 && m_sb[k].v && m_sb[k].rd == idx) sel = k + 1;
        return sel;
    endfunction

    function automatic bit operand_late(input logic [4:0] idx, input logic used);
        int sel = lookup_sel(idx, used);
        if (sel == 0) return 1'b0;
        return (sel - 1) < (m_sb[sel-1].ld ? LOAD_FWD : ALU_FWD);
    endfunction

    function automatic bit wait_now();
        return dmem_req && !dmem_ready;
    endfunction

    function automatic bit raw_now();
        return instr_valid && (operand_late(rs1_idx, rs1_used) || operand_late(rs2_idx, rs2_used));
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        e.en_f = 1'b1;
        e.en_d = 1'b1;
        e.s1 = SEL_W'(lookup_sel(rs1_idx, rs1_used));
        e.s2 = SEL_W'(lookup_sel(rs2_idx, rs2_used));
        e.d1 = (e.s1 != 0);
        e.d2 = (e.s2 != 0);
        if (resetn) begin
            if (wait_now()) begin
                e.freeze = 1'b1; e.en_f = 1'b0; e.en_d = 1'b0;
            end else if (raw_now()) begin
                e.bubble = 1'b1; e.en_f = 1'b0; e.en_d = 1'b0;
            end else if (taken) begin
                e.flush = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < PIPE_DEPTH; k++) m_sb[k] <= '0;
            m_cnt <= 0;
            m_run <= 0;
            m_to  <= 1'b0;
        end else begin
            if (!wait_now()) begin
                for (int k = 1; k < PIPE_DEPTH; k++) m_sb[k] <= m_sb[k-1];
                m_sb[0] <= raw_now() ? ent_t'(0)
                         : {bit'(instr_valid && reg_we && rd_idx != 0), rd_idx, bit'(is_load)};
            end
            if (wait_now() || raw_now()) m_cnt <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_run <= wait_now() ? m_run + 1 : 0;
            if (wait_now() && m_run + 1 >= WAIT_MAX) m_to <= 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = expect_now();
            check("enable_f", enable_f, e.en_f);
            check("enable_d", enable_d, e.en_d);
            check("flush_d", flush_d, e.flush);
            check("bubble_e", bubble_e, e.bubble);
            check("freeze_m", freeze_m, e.freeze);
            check("rs1_sel", rs1_sel, e.s1);
            check("rs2_sel", rs2_sel, e.s2);
            check("rs1_dep", rs1_dep, e.d1);
            check("rs2_dep", rs2_dep, e.d2);
            check("stall_cnt", stall_cnt, m_cnt);
            check("mem_timeout", mem_timeout, m_to);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic tk,
                         input logic req, input logic rdy);
        instr_valid = v;  rs1_idx = r1; rs1_used = u1; rs2_idx = r2; rs2_used = u2;
        rd_idx = rd; reg_we = we; is_load = ld; taken = tk; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        // Memory wait held during reset: outputs must still show idle values.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cmp_en = 1'b1;
        sample();
        check("rst_freeze", freeze_m, 0);
        check("rst_enable_f", enable_f, 1);
        check("rst_stall_cnt", stall_cnt, 0);
        step();
        resetn = 1'b1;

        // add x5
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        sample();
        check("alu_pre_bubble", bubble_e, 0);
        step();
        // add x6,x5,x1 : x5 still in EXE -> one bubble, then forwarded from MEM
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        sample();
        check("alu_raw_bubble", bubble_e, 1);
        check("alu_raw_enable_d", enable_d, 0);
        check("alu_raw_sel_exe", rs1_sel, 1);
        step();
        sample();
        check("alu_fwd_bubble", bubble_e, 0);
        check("alu_fwd_sel", rs1_sel, 2);
        check("alu_fwd_dep", rs1_dep, 1);
        check("alu_stall_cnt", stall_cnt, 1);
        step();

        // lw x7 ; beq x7,x0 : two bubbles, then forwarded from WB
        drive(1, 2, 1, 0, 0, 7, 1, 1, 0, 0, 0);
        step();
        drive(1, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        sample();
        check("lu_bubble1", bubble_e, 1);
        check("lu_sel1", rs1_sel, 1);
        step();
        sample();
        check("lu_bubble2", bubble_e, 1);
        check("lu_sel2", rs1_sel, 2);
        step();
        sample();
        check("lu_release", bubble_e, 0);
        check("lu_sel_wb", rs1_sel, 3);
        check("lu_stall_cnt", stall_cnt, 3);   // one ALU bubble plus two load-use bubbles
        step();

        // add x0, then add x9, then a reader of x9 with rs_used=0 and a taken branch
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        step();
        drive(1, 9, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        sample();
        check("unused_sel1", rs1_sel, 0);
        check("x0_sel2", rs2_sel, 0);
        check("unused_bubble", bubble_e, 0);
        check("taken_flush", flush_d, 1);
        check("taken_enable_f", enable_f, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("flush_one_cycle", flush_d, 0);
        step();

        // add x3 ; taken beq x3 : stall wins over flush
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        sample();
        check("tk_raw_flush", flush_d, 0);
        check("tk_raw_bubble", bubble_e, 1);
        step();

        // Memory wait for 15 cycles: frozen scoreboard, timeout after the 15th
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < WAIT_MAX; i++) begin
            sample();
            check("wait_freeze", freeze_m, 1);
            check("wait_enable_f", enable_f, 0);
            check("wait_sel_held", rs1_sel, 2);
            check("wait_timeout_low", mem_timeout, 0);
            check("wait_stall_cnt", stall_cnt, 4 + i);
            step();
        end
        dmem_ready = 1'b1;
        sample();
        check("ready_freeze", freeze_m, 0);
        check("ready_enable_d", enable_d, 1);
        check("timeout_set", mem_timeout, 1);
        check("timeout_stall_cnt", stall_cnt, 19);
        step();

        // RAW stall, then asynchronous reset in the middle of it
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        step();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("pre_rst_bubble", bubble_e, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_bubble", bubble_e, 0);
        check("mid_rst_enable_d", enable_d, 1);
        check("mid_rst_sel", rs1_sel, 0);
        check("mid_rst_dep", rs1_dep, 0);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_timeout", mem_timeout, 0);
        step();
        resetn = 1'b1;

        // Randomized traffic over a small register set, with one forced long memory wait
        for (int i = 0; i < 500; i++) begin
            if (i >= 200 && i < 217) begin
                drive(1, 5'($urandom_range(0, 7)), 1, 5'($urandom_range(0, 7)), 1,
                      5'($urandom_range(0, 7)), 1, 0, 0, 1, 0);
            end else begin
                drive($urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                      5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0);
            end
            step();
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the in-order MCU pipeline (IF/ID/EXE/MEM/WB, branches resolved in ID).
- Replaces the constant `enable`/`rs1_depended_h` ties in the core top with a scoreboard of in-flight destination registers.
- Handles RAW dependencies, load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Pipeline depth after ID and forwarding points are parameters, so deeper memory stages need no redesign.

Parameters:
- PIPE_DEPTH, 3, scoreboard entries tracked after ID (entry 0 = EXE, 1 = MEM, 2 = WB).
- ALU_FWD_STAGE, 1, lowest entry index whose non-load result may be forwarded to ID.
- LOAD_FWD_STAGE, 2, lowest entry index whose load result may be forwarded to ID.
- MEM_WAIT_MAX, 15, consecutive memory-wait cycles before timeout flag.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- instr_valid_d_i  in  1  ID holds a real instruction
- rs1_idx_d_i / rs2_idx_d_i  in  5 each  ID source indices
- rs1_used_d_i / rs2_used_d_i  in  1 each  source actually read
- rd_idx_d_i  in  5  ID destination
- reg_write_en_d_i  in  1  ID writes rd
- load_d_i  in  1  ID instruction is a load
- taken_d_i  in  1  ID branch/jump redirect
- dmem_req_m_i  in  1  MEM access in progress
- dmem_ready_m_i  in  1  memory completes this cycle
- enable_f_o  out  1  PC/IF register advance
- enable_d_o  out  1  IF/ID register advance
- flush_d_o  out  1  clear IF/ID (squash fetched instr)
- bubble_e_o  out  1  insert NOP into ID/EXE
- freeze_m_o  out  1  hold EXE/MEM/WB registers
- rs1_fwd_sel_o / rs2_fwd_sel_o  out  clog2(PIPE_DEPTH+1) each  0 = regfile, k+1 = entry k
- rs1_depended_h_o / rs2_depended_h_o  out  1 each  operand comes from forwarding
- mem_timeout_o  out  1  sticky memory timeout
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard: PIPE_DEPTH entries of {valid, rd, is_load}. Entry 0 loads from ID, entry k loads from entry k-1.
- Reset (async, resetn=0): all entries invalid, stall_cnt_o=0, mem_timeout_o=0, wait counter=0.
  - Outputs during/after reset: enable_f_o=enable_d_o=1, flush_d_o=bubble_e_o=freeze_m_o=0, fwd_sel=0, depended=0.
- Match rule: source s matches entry k if rs_used=1, rs_idx!=0, entry valid, and rd==rs_idx.
  - The youngest (lowest k) match wins; fwd_sel=k+1, depended=1.
- Not-ready condition for the winning match: (is_load and k<LOAD_FWD_STAGE) or (!is_load and k<ALU_FWD_STAGE).
- mem_wait = dmem_req_m_i & !dmem_ready_m_i.
- Priority 1, mem_wait: freeze_m_o=1, enable_f_o=enable_d_o=0, bubble_e_o=0, flush_d_o=0; scoreboard holds.
- Priority 2, raw_stall (instr_valid_d_i and any source not ready): enable_f_o=enable_d_o=0, bubble_e_o=1.
  - Entries shift with entry 0 invalid.
  - taken_d_i is ignored this cycle (stale operands).
- Priority 3, taken_d_i with no stall: flush_d_o=1, enables=1; ID instruction enters entry 0 normally.
- Otherwise: all enables=1; entry 0 gets {instr_valid_d_i & reg_write_en_d_i & rd!=0, rd_idx_d_i, load_d_i}.
- fwd_sel/depended are combinational from current scoreboard and ID indices; valid even while stalled.
- stall_cnt_o increments by 1 on any cycle with mem_wait or raw_stall; saturates at all-ones.
- Wait counter: increments on consecutive mem_wait cycles, clears otherwise. Reaching MEM_WAIT_MAX sets mem_timeout_o, which stays set until reset.
- All state updates occur at posedge clk. No output is registered except stall_cnt_o and mem_timeout_o.

Test Plan:
- Back-to-back ALU RAW (`add x5`; then `add x6,x5,x1` in ID): cycle 1, x5 in entry 0 -> one-cycle bubble (bubble_e_o=1, enable_d_o=0). Next cycle rs1_fwd_sel_o=2, rs1_depended_h_o=1.
- Load-use (`lw x7`; `beq x7,x0`): two bubble cycles, then rs1_fwd_sel_o=3. stall_cnt_o=2.
- Writes to x0, and rs_used=0 with matching index -> no stall, fwd_sel=0.
- Taken branch with no hazard -> flush_d_o=1 for exactly one cycle, enable_f_o=1. Taken + RAW stall same cycle -> flush_d_o=0, bubble_e_o=1.
- dmem_req_m_i=1, ready low 15 cycles -> freeze_m_o=1 throughout, scoreboard unchanged, mem_timeout_o=1 from cycle 15, stall_cnt_o=15. Ready high -> freeze releases next cycle.
- Assert resetn=0 mid-stall -> outputs immediately return to reset values, entries invalid, counters 0.
